stream_split_32to16: RTL and testbench
======================================

# stream_split_32to16

Width-splitting stream stage that sits directly upstream of the 16-bit input stream wrapper of the MDC coprocessor. It accepts 32-bit words with 4-bit byte strobes from the HWPE streamer and emits 16-bit tokens, low half first, dropping halves whose strobes are all zero. It also counts emitted tokens for the control slave. Full throughput is one token per cycle with no refill bubble.

## Interface
- SKIP_EMPTY, 1: 1 drops halves with both strobe bits zero; 0 emits every half regardless of strobes.
- CNT_W, 16: width of the emitted-token counter.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous flush of the holding register and the counter.
- in_data_i  in  32  input word.
- in_strb_i  in  4  byte strobes of the input word.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  input word accepted when `in_valid_i & in_ready_o`.
- out_data_o  out  16  output token, to the coprocessor input stream wrapper.
- out_strb_o  out  4  `{2'b00, strb of selected half}`.
- out_valid_o  out  1  output token valid.
- out_ready_i  in  1  downstream ready.
- tok_cnt_o  out  CNT_W  number of output handshakes since reset or clear; wraps modulo 2^CNT_W.

## Operation
- Holding register: `word[31:0]`, `strb[3:0]`, state ∈ {EMPTY, LOW, HIGH}.
- `out_valid_o = (state != EMPTY)`.
- In state LOW: `out_data_o = word[15:0]`, `out_strb_o = {2'b00, strb[1:0]}`.
- In state HIGH: `out_data_o = word[31:16]`, `out_strb_o = {2'b00, strb[3:2]}`.
- In state EMPTY: `out_data_o` and `out_strb_o` are 0.
- `last = (state == HIGH) | (state == LOW & hi_skip)`.
  - `hi_skip = SKIP_EMPTY & (strb[3:2] == 0)`.
  - `lo_skip` is defined the same way on `strb[1:0]`.
- `in_ready_o = ~clear_i & ((state == EMPTY) | (out_ready_i & last))`. This is combinational from `out_ready_i`.
- Load on input handshake: store data and strobes. Next state is:
  - LOW if `~lo_skip`;
  - otherwise HIGH if `~hi_skip`;
  - otherwise EMPTY (word consumed, nothing emitted).
- Output handshake in LOW:
  - if not `last`, go to HIGH;
  - if `last`, go to EMPTY, unless a new word loads in the same cycle.
- Output handshake in HIGH: go to EMPTY, unless a new word loads in the same cycle.
- No output handshake: state holds and all outputs remain stable (AXI-stream style; no retraction).
- `tok_cnt_o` increments by 1 on every `out_valid_o & out_ready_i`.
- `clear_i` has priority over all other events:
  - state goes to EMPTY and `tok_cnt_o` goes to 0 on the next edge;
  - any in-flight handshake on the output that cycle is not counted;
  - no input word is accepted while `clear_i` is high.

## Timing
- Reset values: state EMPTY, `out_valid_o` 0, `out_data_o` 0, `out_strb_o` 0, `tok_cnt_o` 0, `in_ready_o` 1 (with `clear_i` low).
- Latency: a word accepted at edge N presents its first token in cycle N+1.
- Throughput:
  - a full-strobe word yields 2 tokens on consecutive cycles;
  - the next word loads on the edge that completes the HIGH handshake, so continuous streams have no bubble;
  - a word with one half skipped yields 1 token per cycle.
- Backpressure: with `out_ready_i` low, `in_ready_o` is 0 whenever state is not EMPTY, and the register holds.
- Reset mid-operation: any pending half is lost and outputs return to reset values on the next edge.
- Counter wrap: `2^CNT_W - 1` + 1 → 0, with no flag.
- Simultaneous clear and output handshake: flush wins and the counter reads 0 afterwards.

## Test plan
- Single word `0xBEEF_1234`, strb `4'hF`, `out_ready_i` held 1 → tokens `0x1234` (strb `4'h3`) then `0xBEEF` (strb `4'h3`) on consecutive cycles; `tok_cnt_o` = 2.
- Back-to-back 4 full-strobe words with `in_valid_i` constant → 8 tokens in 8 consecutive cycles, `in_ready_o` high every second cycle, `tok_cnt_o` = 8.
- Strobe skipping, SKIP_EMPTY = 1:
  - strb `4'hC` → only the high half, with strb `4'h3`;
  - strb `4'h3` → only the low half;
  - strb `4'h0` → no token, `in_ready_o` stays high the next cycle.
  - With SKIP_EMPTY = 0, strb `4'h0` → 2 tokens with strb `4'h0`.
- Random `out_ready_i` (50%) over 200 random words → output sequence equals the reference split-and-skip model, data and strb stable while `out_valid_o & ~out_ready_i`, no token lost or duplicated.
- Pulse `clear_i` while in HIGH with `out_ready_i` = 1 → next cycle `out_valid_o` 0 and `tok_cnt_o` 0; `in_ready_o` is 0 during the pulse. Repeat with `rst_i` → all outputs at reset values.
- With CNT_W = 4, emit 17 tokens → `tok_cnt_o` reads 1.

Source files
------------

// File: rtl/stream_split_32to16.sv
// Splits 32-bit strobed words into 16-bit tokens, low half first, optionally
// dropping halves with no strobes, and counts every emitted token.
module stream_split_32to16 #(
    parameter bit SKIP_EMPTY = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [31:0]      in_data_i,
    input  logic [3:0]       in_strb_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [15:0]      out_data_o,
    output logic [3:0]       out_strb_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] tok_cnt_o
);

    typedef enum logic [1:0] {EMPTY = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      word_reg;
    logic [3:0]       strb_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic hi_skip, lo_skip, in_hi_skip, in_lo_skip;
    logic last, in_hs, out_hs;

    assign hi_skip    = SKIP_EMPTY && (strb_reg[3:2] == 2'b00);
    assign lo_skip    = SKIP_EMPTY && (strb_reg[1:0] == 2'b00);
    assign in_hi_skip = SKIP_EMPTY && (in_strb_i[3:2] == 2'b00);
    assign in_lo_skip = SKIP_EMPTY && (in_strb_i[1:0] == 2'b00);

    // The word is finished once the current token goes out; a new word may
    // load on that same edge, which keeps a continuous stream bubble-free.
    assign last        = (state_reg == HIGH) || ((state_reg == LOW) && hi_skip);
    assign out_valid_o = (state_reg != EMPTY);
    assign in_ready_o  = !clear_i && ((state_reg == EMPTY) || (out_ready_i && last));
    assign in_hs       = in_valid_i && in_ready_o;
    assign out_hs      = out_valid_o && out_ready_i;
    assign tok_cnt_o   = cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= EMPTY;
            word_reg  <= '0;
            strb_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (in_hs) begin
                word_reg <= in_data_i;
                strb_reg <= in_strb_i;
            end
            if (clear_i) begin
                cnt_reg <= '0;
            end else if (out_hs) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear_i) begin
            state_next = EMPTY;
        end else if (in_hs) begin
            if (!in_lo_skip) begin
                state_next = LOW;
            end else if (!in_hi_skip) begin
                state_next = HIGH;
            end else begin
                state_next = EMPTY;
            end
        end else if (out_hs) begin
            if ((state_reg == LOW) && !last) begin
                state_next = HIGH;
            end else begin
                state_next = EMPTY;
            end
        end
    end

    always_comb begin
        out_data_o = 16'h0000;
        out_strb_o = 4'h0;
        case (state_reg)
            LOW: begin
                out_data_o = word_reg[15:0];
                out_strb_o = {2'b00, strb_reg[1:0]};
            end
            HIGH: begin
                out_data_o = word_reg[31:16];
                out_strb_o = {2'b00, strb_reg[3:2]};
            end
            default: begin
                out_data_o = 16'h0000;
                out_strb_o = 4'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_split_32to16.sv
// Directed cycle table, random backpressure scoreboard, and a no-skip
// narrow-counter instance for the wrap check.
module tb_stream_split_32to16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] d   = '0;
    logic [3:0]  s   = '0;
    logic        iv  = 1'b0;
    logic        ir;
    logic [15:0] od;
    logic [3:0]  os;
    logic        ov;
    logic        ordy = 1'b0;
    logic [15:0] cnt;

    logic        clr2  = 1'b0;
    logic [31:0] d2    = '0;
    logic [3:0]  s2    = '0;
    logic        iv2   = 1'b0;
    logic        ir2;
    logic [15:0] od2;
    logic [3:0]  os2;
    logic        ov2;
    logic        ordy2 = 1'b0;
    logic [3:0]  cnt2;

    always #5 clk = ~clk;

    stream_split_32to16 #(.SKIP_EMPTY(1'b1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .in_data_i(d), .in_strb_i(s), .in_valid_i(iv), .in_ready_o(ir),
        .out_data_o(od), .out_strb_o(os), .out_valid_o(ov), .out_ready_i(ordy),
        .tok_cnt_o(cnt)
    );

    stream_split_32to16 #(.SKIP_EMPTY(1'b0), .CNT_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr2),
        .in_data_i(d2), .in_strb_i(s2), .in_valid_i(iv2), .in_ready_o(ir2),
        .out_data_o(od2), .out_strb_o(os2), .out_valid_o(ov2), .out_ready_i(ordy2),
        .tok_cnt_o(cnt2)
    );

    typedef struct {
        logic        rst, clr, iv;
        logic [31:0] d;
        logic [3:0]  s;
        logic        ordy;
        logic        ov;
        logic [15:0] od;
        logic [3:0]  os;
        logic        ir;
        logic [15:0] cnt;
    } vec_t;

    vec_t        vq[$];
    logic [19:0] q[$];
    logic [19:0] q2[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, c, v, input logic [31:0] dd, input logic [3:0] ss,
                       input logic rdy, input logic eov, input logic [15:0] eod,
                       input logic [3:0] eos, input logic eir, input logic [15:0] ecnt);
        vec_t x;
        x.rst = r; x.clr = c; x.iv = v; x.d = dd; x.s = ss; x.ordy = rdy;
        x.ov = eov; x.od = eod; x.os = eos; x.ir = eir; x.cnt = ecnt;
        vq.push_back(x);
    endtask

    function automatic logic keep(input logic skip, input logic [1:0] st);
        return !(skip && (st == 2'b00));
    endfunction

    initial begin
        logic [19:0] e;
        logic        prev_stall;
        logic [15:0] prev_od;
        logic [3:0]  prev_os;
        logic        busy;
        int          sent, cyc, hs, widx;
        logic [15:0] exp_cnt;

        // rst clr iv data strb ordy | ov od os ir cnt
        add(0,0,1,32'hBEEF1234,4'hF,1, 0,16'h0000,4'h0,1,16'd0);
        add(0,0,0,32'h0,       4'h0,1, 1,16'h1234,4'h3,0,16'd0);
        add(0,0,0,32'h0,       4'h0,1, 1,16'hBEEF,4'h3,1,16'd1);
        add(0,0,0,32'h0,       4'h0,1, 0,16'h0000,4'h0,1,16'd2);
        add(0,0,1,32'h11112222,4'hF,1, 0,16'h0000,4'h0,1,16'd2);
        add(0,0,1,32'h33334444,4'hF,1, 1,16'h2222,4'h3,0,16'd2);
        add(0,0,1,32'h33334444,4'hF,1, 1,16'h1111,4'h3,1,16'd3);
        add(0,0,1,32'h55556666,4'hF,1, 1,16'h4444,4'h3,0,16'd4);
        add(0,0,1,32'h55556666,4'hF,1, 1,16'h3333,4'h3,1,16'd5);
        add(0,0,1,32'h77778888,4'hF,1, 1,16'h6666,4'h3,0,16'd6);
        add(0,0,1,32'h77778888,4'hF,1, 1,16'h5555,4'h3,1,16'd7);
        add(0,0,0,32'h0,       4'h0,1, 1,16'h8888,4'h3,0,16'd8);
        add(0,0,0,32'h0,       4'h0,1, 1,16'h7777,4'h3,1,16'd9);
        add(0,0,1,32'hAAAABBBB,4'hC,1, 0,16'h0000,4'h0,1,16'd10);
        add(0,0,1,32'hCCCCDDDD,4'h3,1, 1,16'hAAAA,4'h3,1,16'd10);
        add(0,0,1,32'hEEEEFFFF,4'h0,1, 1,16'hDDDD,4'h3,1,16'd11);
        add(0,0,0,32'h0,       4'h0,1, 0,16'h0000,4'h0,1,16'd12);
        add(0,0,1,32'h12345678,4'hF,0, 0,16'h0000,4'h0,1,16'd12);
        add(0,0,1,32'h9ABCDEF0,4'hF,0, 1,16'h5678,4'h3,0,16'd12);
        add(0,0,1,32'h9ABCDEF0,4'hF,1, 1,16'h5678,4'h3,0,16'd12);
        add(0,0,1,32'h9ABCDEF0,4'hF,0, 1,16'h1234,4'h3,0,16'd13);
        add(0,0,1,32'h9ABCDEF0,4'hF,1, 1,16'h1234,4'h3,1,16'd13);
        add(0,0,0,32'h0,       4'h0,1, 1,16'hDEF0,4'h3,0,16'd14);
        add(0,1,1,32'h0BADF00D,4'hF,1, 1,16'h9ABC,4'h3,0,16'd15);
        add(0,0,1,32'h0BADF00D,4'hF,1, 0,16'h0000,4'h0,1,16'd0);
        add(0,0,0,32'h0,       4'h0,1, 1,16'hF00D,4'h3,0,16'd0);
        add(1,0,0,32'h0,       4'h0,1, 1,16'h0BAD,4'h3,1,16'd1);
        add(0,0,0,32'h0,       4'h0,1, 0,16'h0000,4'h0,1,16'd0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; clr = vq[i].clr; iv = vq[i].iv;
            d = vq[i].d; s = vq[i].s; ordy = vq[i].ordy;
            #1;
            $display("vec %0d: ov=%b od=%h os=%h ir=%b cnt=%0d", i, ov, od, os, ir, cnt);
            chk($sformatf("vec%0d out_valid", i), 32'(ov), 32'(vq[i].ov));
            chk($sformatf("vec%0d out_data", i),  32'(od), 32'(vq[i].od));
            chk($sformatf("vec%0d out_strb", i),  32'(os), 32'(vq[i].os));
            chk($sformatf("vec%0d in_ready", i),  32'(ir), 32'(vq[i].ir));
            chk($sformatf("vec%0d tok_cnt", i),   32'(cnt), 32'(vq[i].cnt));
        end

        // Random backpressure against a split-and-skip reference queue.
        busy = 1'b0; sent = 0; cyc = 0; prev_stall = 1'b0;
        prev_od = '0; prev_os = '0; exp_cnt = '0;
        while ((sent < 200 || q.size() > 0 || ov) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            ordy = 1'($urandom_range(0, 1));
            if (!busy) begin
                if (sent < 200) begin
                    d = $urandom; s = 4'($urandom_range(0, 15)); iv = 1'b1; busy = 1'b1;
                end else begin
                    iv = 1'b0;
                end
            end
            #1;
            chk("rand tok_cnt", 32'(cnt), 32'(exp_cnt));
            if (prev_stall) begin
                chk("rand stall valid", 32'(ov), 32'd1);
                chk("rand stall data", {12'h0, os, od}, {12'h0, prev_os, prev_od});
            end
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    chk("rand extra token", {12'h0, os, od}, 32'hFFFFFFFF);
                end else begin
                    e = q.pop_front();
                    $display("rand token: data=%h strb=%h", od, os);
                    chk("rand token", {12'h0, os, od}, {12'h0, e[3:0], e[19:4]});
                end
                exp_cnt++;
            end
            prev_stall = ov && !ordy;
            prev_od = od; prev_os = os;
            if (iv && ir) begin
                if (keep(1'b1, s[1:0])) q.push_back({d[15:0], 2'b00, s[1:0]});
                if (keep(1'b1, s[3:2])) q.push_back({d[31:16], 2'b00, s[3:2]});
                sent++;
                busy = 1'b0;
            end
        end
        chk("rand words sent", 32'(sent), 32'd200);
        chk("rand queue drained", 32'(q.size()), 32'd0);
        @(negedge clk);
        iv = 1'b0; ordy = 1'b0;

        // No-skip instance: empty strobes still emit, 4-bit counter wraps at 16.
        hs = 0; widx = 0; cyc = 0;
        while (hs < 17 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            ordy2 = 1'b1;
            if (widx < 9) begin
                iv2 = 1'b1;
                d2 = 32'hA5A55A5A ^ {widx[15:0], widx[15:0]};
                s2 = (widx == 0) ? 4'h0 : 4'hF;
            end else begin
                iv2 = 1'b0;
            end
            #1;
            chk("noskip tok_cnt", 32'(cnt2), 32'(hs % 16));
            if (ov2 && ordy2) begin
                if (q2.size() == 0) begin
                    chk("noskip extra token", {12'h0, os2, od2}, 32'hFFFFFFFF);
                end else begin
                    e = q2.pop_front();
                    $display("noskip token %0d: data=%h strb=%h", hs, od2, os2);
                    chk("noskip token", {12'h0, os2, od2}, {12'h0, e[3:0], e[19:4]});
                end
                hs++;
            end
            if (iv2 && ir2) begin
                q2.push_back({d2[15:0], 2'b00, s2[1:0]});
                q2.push_back({d2[31:16], 2'b00, s2[3:2]});
                widx++;
            end
        end
        chk("noskip handshakes", 32'(hs), 32'd17);
        @(negedge clk);
        ordy2 = 1'b0; iv2 = 1'b0;
        #1;
        chk("noskip wrap tok_cnt", 32'(cnt2), 32'd1);
        chk("noskip pending valid", 32'(ov2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
